// File: rtl/butterfly_pkg.sv
// Shared constants and sample type for the CORDIC butterfly pipeline (shift 5..8)
// and its issue/result controller.
package butterfly_pkg;
    localparam int WIDTH      = 22;
    localparam int NUM_STAGES = 4;
    localparam int SHIFT_BASE = 5;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } sample_t;
endpackage

// File: rtl/butterfly_fifo.sv
// Synchronous result FIFO; full/empty derived from an entry count so the
// power-of-two pointers may simply wrap.
module butterfly_fifo #(
    parameter int DW    = 44,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Credit-based admission upstream must make this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));
endmodule

// File: rtl/butterfly_sched.sv
// Issue controller for the 4-stage CORDIC butterfly pipeline: launches samples,
// aligns per-stage direction bits, and buffers results behind credit-based admission.
module butterfly_sched #(
    parameter int WIDTH      = butterfly_pkg::WIDTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [3:0]       in_b,
    output logic [WIDTH-1:0] pipe_x,
    output logic [WIDTH-1:0] pipe_y,
    output logic [3:0]       pipe_b,
    input  logic [WIDTH-1:0] pipe_xr,
    input  logic [WIDTH-1:0] pipe_yr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             busy
);
    import butterfly_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Handshakes: a transfer occurs on a rising edge where valid && ready;
    // ready depends only on registered state, valid may not wait on ready.
    logic                accept, pop, capture;
    logic [NUM_STAGES:0] v_q;
    logic [CW-1:0]       occ_q, occ_d;
    logic [WIDTH-1:0]    x_q, y_q;
    logic [3:0]          b_q;
    logic                d2_q;
    logic [1:0]          d1_q;
    logic [2:0]          d0_q;
    logic                fifo_empty;
    logic [2*WIDTH-1:0]  fifo_rdata;

    assign in_ready  = (occ_q < CW'(FIFO_DEPTH)) && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign capture   = v_q[NUM_STAGES];
    assign busy      = (occ_q != '0);

    assign pipe_x = x_q;
    assign pipe_y = y_q;
    assign pipe_b = {b_q[3], d2_q, d1_q[1], d0_q[2]};
    assign out_x  = fifo_rdata[2*WIDTH-1:WIDTH];
    assign out_y  = fifo_rdata[WIDTH-1:0];

    // Occupancy counts in-flight plus buffered samples, reserving a FIFO slot at accept.
    always_comb begin
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            occ_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            b_q   <= '0;
            d2_q  <= 1'b0;
            d1_q  <= '0;
            d0_q  <= '0;
        end else begin
            v_q   <= {v_q[NUM_STAGES-1:0], accept};
            occ_q <= occ_d;
            if (accept) begin
                x_q <= in_x;
                y_q <= in_y;
                b_q <= in_b;
            end
            // Delay taps shift every cycle; bubble slots carry unused bits.
            d2_q <= b_q[2];
            d1_q <= {d1_q[0], b_q[1]};
            d0_q <= {d0_q[1:0], b_q[0]};
        end
    end

    butterfly_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (capture),
        .pop_i   (pop),
        .wdata_i ({pipe_xr, pipe_yr}),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_butterfly_sched.sv
// Bench for butterfly_sched with a behavioural 4-stage CORDIC pipeline beside it
// and an acceptance-order scoreboard on the result port.
module tb_butterfly_sched;
    import butterfly_pkg::*;

    localparam int W     = WIDTH;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0] in_x, in_y, pipe_x, pipe_y, pipe_xr, pipe_yr, out_x, out_y;
    logic [3:0]   in_b, pipe_b;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] sb_exp;
    logic [2*W-1:0] st_q [4];

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [3:0]   b;
        logic [W-1:0] ex;
        logic [W-1:0] ey;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    butterfly_sched #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_b(in_b),
        .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_b(pipe_b),
        .pipe_xr(pipe_xr), .pipe_yr(pipe_yr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .busy(busy)
    );

    // One micro-rotation: b=1 rotates with d=+1, b=0 with d=-1.
    function automatic logic [2*W-1:0] stage_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic b, input int s);
        logic signed [W-1:0] xs, ys, xn, yn;
        xs = x;
        ys = y;
        if (b) begin
            xn = xs - (ys >>> s);
            yn = ys + (xs >>> s);
        end else begin
            xn = xs + (ys >>> s);
            yn = ys - (xs >>> s);
        end
        return {xn, yn};
    endfunction

    function automatic logic [2*W-1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic [3:0] b);
        logic [2*W-1:0] r;
        r = {x, y};
        for (int k = 0; k < NUM_STAGES; k++)
            r = stage_f(r[2*W-1:W], r[W-1:0], b[3-k], SHIFT_BASE + k);
        return r;
    endfunction

    // Behavioural pipeline: one register per stage, each fed its own pipe_b bit.
    always @(posedge clk) begin
        st_q[0] <= stage_f(pipe_x, pipe_y, pipe_b[3], 5);
        st_q[1] <= stage_f(st_q[0][2*W-1:W], st_q[0][W-1:0], pipe_b[2], 6);
        st_q[2] <= stage_f(st_q[1][2*W-1:W], st_q[1][W-1:0], pipe_b[1], 7);
        st_q[3] <= stage_f(st_q[2][2*W-1:W], st_q[2][W-1:0], pipe_b[0], 8);
    end
    assign pipe_xr = st_q[3][2*W-1:W];
    assign pipe_yr = st_q[3][W-1:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push at accept, pop and compare at each output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got %0h_%0h with nothing expected", out_x, out_y);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("sb_result", {20'h0, out_x, out_y}, {20'h0, sb_exp});
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                exp_q.push_back(ref_model(in_x, in_y, in_b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic drive_rand();
        in_x = W'($urandom);
        in_y = W'($urandom);
        in_b = 4'($urandom);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check(name, {63'h0, busy}, 64'h0);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'h0);
    endtask

    task automatic run_vec(input int i);
        int lat;
        bit got;
        got = 1'b0;
        lat = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_x = vecs[i].x;
        in_y = vecs[i].y;
        in_b = vecs[i].b;
        half();
        check("vec_in_ready", {63'h0, in_ready}, 64'h1);
        step();
        in_valid = 1'b0;
        drive_rand();
        for (int c = 1; c <= 12; c++) begin
            half();
            if (c == 1) begin
                check("vec_pipe_x", 64'(pipe_x), 64'(vecs[i].x));
                check("vec_pipe_y", 64'(pipe_y), 64'(vecs[i].y));
            end
            if (c <= 4) check($sformatf("vec_pipe_b%0d", 4 - c), {63'h0, pipe_b[4-c]},
                              {63'h0, vecs[i].b[4-c]});
            if (out_valid && !got) begin
                got = 1'b1;
                lat = c;
                check("vec_out_x", 64'(out_x), 64'(vecs[i].ex));
                check("vec_out_y", 64'(out_y), 64'(vecs[i].ey));
            end
            step();
        end
        check("vec_latency", 64'(lat), 64'd6);
    endtask

    initial begin
        int a0, p0;
        int n;

        vecs[0] = '{x: 22'h000100, y: 22'h000000, b: 4'b1010, ex: 22'h000100, ey: 22'h000005};
        vecs[1] = '{x: 22'h000000, y: 22'h000100, b: 4'b0000, ex: 22'h00000F, ey: 22'h000100};
        vecs[2] = '{x: 22'h000100, y: 22'h000100, b: 4'b1111, ex: 22'h0000F1, ey: 22'h00010C};
        vecs[3] = '{x: 22'h3FFF00, y: 22'h000000, b: 4'b1010, ex: 22'h3FFEFF, ey: 22'h3FFFFA};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_x = '0;
        in_y = '0;
        in_b = '0;
        step();
        step();
        half();
        check("rst_in_ready", {63'h0, in_ready}, 64'h0);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_pipe_xy", {20'h0, pipe_x, pipe_y}, 64'h0);
        check("rst_pipe_b", {60'h0, pipe_b}, 64'h0);
        step();
        rst_n = 1'b1;
        half();
        check("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
        step();

        for (int i = 0; i < 4; i++) run_vec(i);

        // Streaming: 32 back-to-back samples, consumer always ready.
        p0 = pop_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = (i < 32);
            drive_rand();
            half();
            if (i < 32) check("stream_in_ready", {63'h0, in_ready}, 64'h1);
            if (i >= 6 && i < 38) check("stream_out_valid", {63'h0, out_valid}, 64'h1);
            if (i == 37) check("stream_busy_last", {63'h0, busy}, 64'h1);
            if (i == 38) begin
                check("stream_busy_fall", {63'h0, busy}, 64'h0);
                check("stream_out_idle", {63'h0, out_valid}, 64'h0);
            end
            step();
        end
        check("stream_pop_count", 64'(pop_cnt - p0), 64'd32);

        // Backpressure: credits cap admission at DEPTH.
        a0 = acc_cnt;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            step();
        end
        check("bp_accepts", 64'(acc_cnt - a0), 64'(DEPTH));
        half();
        check("bp_in_ready_low", {63'h0, in_ready}, 64'h0);
        step();
        a0 = acc_cnt;
        out_ready = 1'b1;
        half();
        check("bp_pop_cycle_ready", {63'h0, in_ready}, 64'h0);
        step();
        out_ready = 1'b0;
        half();
        check("bp_after_pop_ready", {63'h0, in_ready}, 64'h1);
        step();
        for (int i = 0; i < 10; i++) begin
            drive_rand();
            step();
        end
        check("bp_one_more", 64'(acc_cnt - a0), 64'd1);
        drain("bp_drain");

        // Accept and pop together at occupancy DEPTH-1.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive_rand();
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        in_valid = 1'b1;
        out_ready = 1'b1;
        drive_rand();
        half();
        check("occ7_in_ready", {63'h0, in_ready}, 64'h1);
        check("occ7_out_valid", {63'h0, out_valid}, 64'h1);
        step();
        a0 = acc_cnt;
        out_ready = 1'b0;
        drive_rand();
        half();
        check("occ7_hold_ready", {63'h0, in_ready}, 64'h1);
        for (int i = 0; i < 6; i++) begin
            step();
            drive_rand();
        end
        check("occ7_one_slot", 64'(acc_cnt - a0), 64'd1);
        drain("occ7_drain");

        // Reset with 4 buffered and 3 in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        half();
        check("mid_rst_in_ready", {63'h0, in_ready}, 64'h0);
        step();
        rst_n = 1'b1;
        half();
        check("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("mid_rst_busy", {63'h0, busy}, 64'h0);
        check("mid_rst_in_ready_back", {63'h0, in_ready}, 64'h1);
        step();
        p0 = pop_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("mid_rst_no_stale", 64'(pop_cnt - p0), 64'd0);

        // Random traffic at 50% valid/ready.
        a0 = acc_cnt;
        n = 0;
        while ((acc_cnt - a0) < 10000 && n < 60000) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            drive_rand();
            step();
            n++;
        end
        check("rand_accepts", 64'(acc_cnt - a0), 64'd10000);
        drain("rand_drain");
        check("total_pops", 64'(pop_cnt), 64'(acc_cnt - 7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/butterfly_sched.md
# butterfly_sched

Issue controller and result buffer for the four-stage CORDIC butterfly pipeline (shift amounts 5, 6, 7, 8). It accepts X/Y samples with a 4-bit direction word over a valid/ready handshake. It launches each accepted sample into the non-stallable pipeline and feeds each stage its direction bit in the cycle that stage processes the sample. It tracks every in-flight sample and captures results into an output FIFO, using credit-based admission so no result is ever dropped under downstream backpressure.

## Interface
- WIDTH, 22, data width of X/Y samples.
- FIFO_DEPTH, 8, result FIFO entries (power of two, ≥ 5).
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input sample offered.
- in_ready  out  1  block can accept a sample this cycle.
- in_x, in_y  in  WIDTH  input sample.
- in_b  in  4  direction bits; [3] for shift-5 stage ... [0] for shift-8 stage.
- pipe_x, pipe_y  out  WIDTH  launch register, drives pipeline X5/Y5.
- pipe_b  out  4  per-stage aligned direction bits, drives pipeline b.
- pipe_xr, pipe_yr  in  WIDTH  pipeline result (X9/Y9).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_x, out_y  out  WIDTH  FIFO head.
- busy  out  1  any sample in flight or buffered.

## Operation
- Accept when in_valid && in_ready; load in_x/in_y/in_b into the launch register; set launch valid bit v[0].
- Valid shift register v[4:0] advances every cycle; v[k+1] <= v[k]; v[0] <= accept.
- Direction delay line: pipe_b[3] = launch b[3]; pipe_b[2] = b[2] delayed 1; pipe_b[1] = b[1] delayed 2; pipe_b[0] = b[0] delayed 3. Delay registers load unconditionally; bubble slots carry don't-care bits whose results are discarded.
- Capture: when v[4]=1, write pipe_xr/pipe_yr into the FIFO; otherwise ignore pipeline outputs.
- Pop: out_valid && out_ready removes the head.
- Occupancy = popcount(v[4:0]) + fifo_count, kept as one registered counter: +1 on accept, −1 on pop, unchanged on both.
- in_ready = (occupancy < FIFO_DEPTH) && rst_n, from registered state only (no combinational path from in_valid or out_ready).
- FIFO can never overflow; a capture with the FIFO full is an assertion failure.
- busy = (occupancy != 0).
- No sample is reordered or duplicated; output order equals acceptance order.

## Timing
- Accept in cycle t: pipe_x/pipe_y/pipe_b[3] valid in t+1, pipe_b[2] in t+2, pipe_b[1] in t+3, pipe_b[0] in t+4. Each pipeline stage registers once, so the result is on pipe_xr/pipe_yr in t+5.
- Result is written at the end of t+5; out_valid is high from t+6, giving 6 cycles of accept-to-out_valid latency.
- Sustained throughput is 1 sample/cycle while out_ready=1.
- A pop in cycle t raises in_ready in t+1 at the earliest.
- Reset (rst_n low at a clock edge):
  - v, the occupancy counter and the FIFO pointers clear.
  - out_valid=0, in_ready=0 during the reset cycle, busy=0, pipe_x/pipe_y/pipe_b = 0.
  - FIFO data and delay-line contents are don't-care after reset.
- Reset mid-operation discards all in-flight and buffered samples. in_ready returns to 1 in the first cycle after rst_n is high.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by count, not by pointer equality.

## Structure
- Shared package butterfly_pkg: WIDTH (22), NUM_STAGES (4), SHIFT_BASE (5), and a typedef for the {x, y} sample pair. The pipeline wrapper and this block both import it.
- One sub-module: butterfly_fifo, a synchronous FIFO (WIDTH*2 data, FIFO_DEPTH entries, push/pop/count, same clk/rst_n).
- The pipeline itself stays outside; this block is instantiated beside it and wired port-to-port.

## Test plan
- Single sample: accept x=0x00100, y=0, b=4'b1010 at t=0. Check pipe_b[3]=1 at t=1, pipe_b[2]=0 at t=2, pipe_b[1]=1 at t=3, pipe_b[0]=0 at t=4, and out_valid at t=6 carrying the reference-model result.
- Streaming: 32 back-to-back samples with out_ready=1. Check in_ready stays 1, outputs appear at 1/cycle in order, and busy falls 6 cycles after the last accept.
- Backpressure: out_ready=0 with continuous in_valid. Check exactly 8 accepts, then in_ready=0. Raise out_ready for 1 cycle and check exactly one more accept; confirm no loss.
- Simultaneous accept and pop at occupancy 8 minus 1 (7). Check occupancy holds at 7 and in_ready stays 1.
- Reset mid-operation: with 3 samples in flight and 4 buffered, pull rst_n low for 1 cycle. Check out_valid=0 and busy=0 next cycle, in_ready=1 one cycle after rst_n rises, and no stale results emerge.
- Random: random valid/ready at 50% for 10k samples against a scoreboard. Check order, values, and the no-overflow assertion.
